// File: rtl/retire_recovery_ctrl_pkg.sv
// Shared types for the retire/recovery sequencer: retire width and the
// recovery FSM state encoding.
package retire_ctrl_pkg;

    localparam int RETIRE_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } rcv_state_t;

endpackage

// File: rtl/retire_recovery_ctrl_if.sv
// ROB retire bundle between the reorder buffer (master) and the retire
// recovery sequencer (slave).
interface retire_recovery_ctrl_if #(
    parameter int XLEN = 32
) ();
    import retire_ctrl_pkg::*;

    // Handshake: retire_valid[i] offers slot i this cycle; the slot retires only when
    // commit_mask[i] is also 1 in the same cycle. Offers not accepted are dropped, not queued.
    logic [RETIRE_W-1:0]           retire_valid;
    logic [RETIRE_W-1:0]           retire_precise_need;
    logic [RETIRE_W-1:0]           retire_halt;
    logic [RETIRE_W-1:0][XLEN-1:0] retire_target_pc;
    logic [RETIRE_W-1:0]           commit_mask;

    modport master (
        output retire_valid,
        output retire_precise_need,
        output retire_halt,
        output retire_target_pc,
        input  commit_mask
    );

    modport slave (
        input  retire_valid,
        input  retire_precise_need,
        input  retire_halt,
        input  retire_target_pc,
        output commit_mask
    );

endinterface

// File: rtl/retire_recovery_ctrl_event_pick.sv
// Combinational oldest-event finder: slot 2 is oldest, so the highest flagged
// valid slot wins and every younger (lower) slot is squashed.
module retire_event_pick
    import retire_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [RETIRE_W-1:0]           retire_valid,
    input  logic [RETIRE_W-1:0]           precise_need,
    input  logic [RETIRE_W-1:0]           halt,
    input  logic [RETIRE_W-1:0][XLEN-1:0] target_pc,
    output logic [RETIRE_W-1:0]           commit_mask,
    output logic                          ev_valid,
    output logic                          ev_is_halt,
    output logic [XLEN-1:0]               ev_pc
);

    // Ascending scan: the last hit is the oldest event and overrides younger ones.
    always_comb begin
        commit_mask = retire_valid;
        ev_valid    = 1'b0;
        ev_is_halt  = 1'b0;
        ev_pc       = '0;
        for (int i = 0; i < RETIRE_W; i++) begin
            if (retire_valid[i] && (precise_need[i] || halt[i])) begin
                ev_valid    = 1'b1;
                ev_is_halt  = halt[i];
                ev_pc       = target_pc[i];
                commit_mask = retire_valid;
                for (int j = 0; j < i; j++) begin
                    commit_mask[j] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/retire_recovery_ctrl.sv
// Retire recovery sequencer: gates commits behind the oldest mispredict/halt,
// pulses the flush and fetch redirect, and holds dispatch through the drain.
module retire_recovery_ctrl
    import retire_ctrl_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int RECOVER_CYCLES = 2,
    parameter int CNT_W          = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    retire_recovery_ctrl_if.slave  rif,
    input  logic                   sq_drained,
    output logic                   bp_recover_en,
    output logic                   redirect_valid,
    output logic [XLEN-1:0]        redirect_pc,
    output logic                   dispatch_hold,
    output logic                   halted,
    output logic [CNT_W-1:0]       mispredict_count,
    output rcv_state_t             state_dbg
);

    localparam int WAIT_W = (RECOVER_CYCLES > 0) ? $clog2(RECOVER_CYCLES + 1) : 1;

    rcv_state_t          state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [RETIRE_W-1:0] pick_mask;
    logic                ev_valid;
    logic                ev_is_halt;
    logic [XLEN-1:0]     ev_pc;

    retire_event_pick #(.XLEN(XLEN)) u_pick (
        .retire_valid (rif.retire_valid),
        .precise_need (rif.retire_precise_need),
        .halt         (rif.retire_halt),
        .target_pc    (rif.retire_target_pc),
        .commit_mask  (pick_mask),
        .ev_valid     (ev_valid),
        .ev_is_halt   (ev_is_halt),
        .ev_pc        (ev_pc)
    );

    // Commits only flow in IDLE; everything offered during recovery is dropped.
    assign rif.commit_mask = (state == IDLE && !reset) ? pick_mask : '0;
    assign state_dbg       = state;

    // redirect_pc doubles as the latched recovery PC; it is nonzero only in FLUSH.
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            wait_cnt         <= '0;
            bp_recover_en    <= 1'b0;
            redirect_valid   <= 1'b0;
            redirect_pc      <= '0;
            dispatch_hold    <= 1'b0;
            halted           <= 1'b0;
            mispredict_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ev_valid && ev_is_halt) begin
                        state         <= HALT;
                        halted        <= 1'b1;
                        dispatch_hold <= 1'b1;
                    end else if (ev_valid) begin
                        state            <= FLUSH;
                        bp_recover_en    <= 1'b1;
                        redirect_valid   <= 1'b1;
                        redirect_pc      <= ev_pc;
                        dispatch_hold    <= 1'b1;
                        mispredict_count <= mispredict_count + CNT_W'(1);
                    end
                end
                FLUSH: begin
                    state          <= DRAIN;
                    wait_cnt       <= WAIT_W'(RECOVER_CYCLES);
                    bp_recover_en  <= 1'b0;
                    redirect_valid <= 1'b0;
                    redirect_pc    <= '0;
                end
                DRAIN: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end else if (sq_drained) begin
                        state         <= IDLE;
                        dispatch_hold <= 1'b0;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_retire_recovery_ctrl.sv
// Self-checking bench for retire_recovery_ctrl with a timeline-level reference model.
module tb_retire_recovery_ctrl;
    import retire_ctrl_pkg::*;

    localparam int XLEN = 32;
    localparam int RC   = 2;
    localparam int CW   = 16;

    logic            clock;
    logic            reset;
    logic            sq_drained;
    logic            bp_recover_en;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            dispatch_hold;
    logic            halted;
    logic [CW-1:0]   mispredict_count;
    rcv_state_t      state_dbg;

    retire_recovery_ctrl_if #(.XLEN(XLEN)) rif ();

    retire_recovery_ctrl #(.XLEN(XLEN), .RECOVER_CYCLES(RC), .CNT_W(CW)) dut (
        .clock            (clock),
        .reset            (reset),
        .rif              (rif.slave),
        .sq_drained       (sq_drained),
        .bp_recover_en    (bp_recover_en),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .dispatch_hold    (dispatch_hold),
        .halted           (halted),
        .mispredict_count (mispredict_count),
        .state_dbg        (state_dbg)
    );

    // Clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [CW-1:0] exp_count = '0;

    // Reference model: walk from the oldest slot; keep valid slots up to and including the first event.
    function automatic logic [2:0] model_mask(input logic [2:0] v, input logic [2:0] pn, input logic [2:0] h);
        logic [2:0] m;
        m = 3'b000;
        for (int s = 2; s >= 0; s--) begin
            if (v[s]) m[s] = 1'b1;
            if (v[s] && (pn[s] || h[s])) break;
        end
        return m;
    endfunction

    function automatic int model_event_slot(input logic [2:0] v, input logic [2:0] pn, input logic [2:0] h);
        for (int s = 2; s >= 0; s--) begin
            if (v[s] && (pn[s] || h[s])) return s;
        end
        return -1;
    endfunction

    // Drain lasts until the counter has expired and the store queue reports empty.
    function automatic int model_drain_len(input int d);
        return ((d > RC) ? d : RC) + 1;
    endfunction

    // Driver tasks
    task automatic drive_retire(input logic [2:0] v, input logic [2:0] pn, input logic [2:0] h,
                                input logic [2:0][XLEN-1:0] pcs);
        rif.retire_valid        = v;
        rif.retire_precise_need = pn;
        rif.retire_halt         = h;
        rif.retire_target_pc    = pcs;
    endtask

    task automatic drive_garbage();
        drive_retire(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                     {$urandom, $urandom, $urandom});
    endtask

    task automatic drive_idle();
        drive_retire(3'b000, 3'b000, 3'b000, '0);
    endtask

    task automatic apply_reset(input int cycles);
        reset = 1'b1;
        drive_retire(3'b111, 3'b000, 3'b000, '0);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            #1;
            n_checks++;
            if ({bp_recover_en, redirect_valid, dispatch_hold, halted} !== 4'b0000 || redirect_pc !== '0)
                $display("FAIL reset_outputs: bp=%b rv=%b hold=%b halted=%b pc=%h, want all 0",
                         bp_recover_en, redirect_valid, dispatch_hold, halted, redirect_pc);
            else n_pass++;
            n_checks++;
            if (mispredict_count !== '0) $display("FAIL reset_count: got %0d want 0", mispredict_count);
            else n_pass++;
            n_checks++;
            if (rif.commit_mask !== 3'b000) $display("FAIL reset_mask: got %b want 000", rif.commit_mask);
            else n_pass++;
        end
        reset = 1'b0;
        drive_idle();
        exp_count = '0;
    endtask

    // Full mispredict scenario: event cycle, flush cycle, drain with d cycles of sq not drained.
    task automatic run_mispredict(input string name, input logic [2:0] v, input logic [2:0] pn,
                                  input logic [2:0][XLEN-1:0] pcs, input int d);
        int slot;
        int len;
        logic [XLEN-1:0] exp_pc;
        @(negedge clock);
        sq_drained = 1'b1;
        drive_retire(v, pn, 3'b000, pcs);
        #1;
        n_checks++;
        if (rif.commit_mask !== model_mask(v, pn, 3'b000))
            $display("FAIL %s_mask: got %b want %b", name, rif.commit_mask, model_mask(v, pn, 3'b000));
        else n_pass++;
        slot      = model_event_slot(v, pn, 3'b000);
        exp_pc    = pcs[slot];
        exp_count = exp_count + 1'b1;
        @(negedge clock);
        drive_garbage();
        #1;
        n_checks++;
        if (bp_recover_en !== 1'b1 || redirect_valid !== 1'b1 || dispatch_hold !== 1'b1)
            $display("FAIL %s_flush: bp=%b rv=%b hold=%b want 1 1 1", name, bp_recover_en, redirect_valid, dispatch_hold);
        else n_pass++;
        n_checks++;
        if (redirect_pc !== exp_pc) $display("FAIL %s_redirect_pc: got %h want %h", name, redirect_pc, exp_pc);
        else n_pass++;
        n_checks++;
        if (mispredict_count !== exp_count)
            $display("FAIL %s_count: got %0d want %0d", name, mispredict_count, exp_count);
        else n_pass++;
        n_checks++;
        if (rif.commit_mask !== 3'b000) $display("FAIL %s_flush_mask: got %b want 000", name, rif.commit_mask);
        else n_pass++;
        @(negedge clock);
        len = 0;
        while (dispatch_hold === 1'b1 && len < 64) begin
            sq_drained = (len >= d);
            drive_garbage();
            #1;
            n_checks++;
            if (rif.commit_mask !== 3'b000 || bp_recover_en !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== '0)
                $display("FAIL %s_drain: mask=%b bp=%b rv=%b pc=%h want 000 0 0 0",
                         name, rif.commit_mask, bp_recover_en, redirect_valid, redirect_pc);
            else n_pass++;
            len++;
            @(negedge clock);
        end
        drive_idle();
        sq_drained = 1'b1;
        n_checks++;
        if (len !== model_drain_len(d))
            $display("FAIL %s_drain_len: got %0d cycles want %0d", name, len, model_drain_len(d));
        else n_pass++;
    endtask

    task automatic test_reset();
        apply_reset(2);
    endtask

    task automatic test_no_event();
        @(negedge clock);
        drive_retire(3'b111, 3'b000, 3'b000, {32'h300, 32'h200, 32'h100});
        #1;
        n_checks++;
        if (rif.commit_mask !== 3'b111) $display("FAIL no_event_mask: got %b want 111", rif.commit_mask);
        else n_pass++;
        @(negedge clock);
        drive_idle();
        #1;
        n_checks++;
        if (bp_recover_en !== 1'b0 || dispatch_hold !== 1'b0)
            $display("FAIL no_event_quiet: bp=%b hold=%b want 0 0", bp_recover_en, dispatch_hold);
        else n_pass++;
    endtask

    task automatic test_mispredict();
        run_mispredict("mispredict", 3'b111, 3'b010, {32'h0000_2000, 32'h0000_1040, 32'h0000_3000}, 0);
    endtask

    task automatic test_sq_stall();
        run_mispredict("sq_stall", 3'b111, 3'b010, {32'h0000_2000, 32'h0000_1040, 32'h0000_3000}, 6);
    endtask

    task automatic test_random();
        logic [2:0] vt [4];
        logic [2:0] v;
        logic [2:0] pn;
        vt = '{3'b000, 3'b100, 3'b110, 3'b111};
        for (int it = 0; it < 24; it++) begin
            v  = vt[$urandom_range(0, 3)];
            pn = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 7)) : 3'b000;
            if (model_event_slot(v, pn, 3'b000) >= 0) begin
                run_mispredict("random", v, pn, {$urandom, $urandom, $urandom}, $urandom_range(0, 5));
            end else begin
                @(negedge clock);
                drive_retire(v, pn, 3'b000, {$urandom, $urandom, $urandom});
                #1;
                n_checks++;
                if (rif.commit_mask !== model_mask(v, pn, 3'b000))
                    $display("FAIL random_idle_mask: got %b want %b", rif.commit_mask, model_mask(v, pn, 3'b000));
                else n_pass++;
                @(negedge clock);
                drive_idle();
                #1;
                n_checks++;
                if (bp_recover_en !== 1'b0 || dispatch_hold !== 1'b0)
                    $display("FAIL random_idle_quiet: bp=%b hold=%b want 0 0", bp_recover_en, dispatch_hold);
                else n_pass++;
            end
        end
    endtask

    task automatic test_halt();
        @(negedge clock);
        drive_retire(3'b111, 3'b010, 3'b100, {32'h4000, 32'h5000, 32'h6000});
        #1;
        n_checks++;
        if (rif.commit_mask !== model_mask(3'b111, 3'b010, 3'b100))
            $display("FAIL halt_mask: got %b want %b", rif.commit_mask, model_mask(3'b111, 3'b010, 3'b100));
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            drive_garbage();
            #1;
            n_checks++;
            if (halted !== 1'b1 || dispatch_hold !== 1'b1 || bp_recover_en !== 1'b0 || rif.commit_mask !== 3'b000)
                $display("FAIL halt_sticky: halted=%b hold=%b bp=%b mask=%b want 1 1 0 000",
                         halted, dispatch_hold, bp_recover_en, rif.commit_mask);
            else n_pass++;
            n_checks++;
            if (mispredict_count !== exp_count)
                $display("FAIL halt_count: got %0d want %0d", mispredict_count, exp_count);
            else n_pass++;
        end
        drive_idle();
    endtask

    task automatic test_reset_in_drain();
        apply_reset(1);
        @(negedge clock);
        sq_drained = 1'b0;
        drive_retire(3'b100, 3'b100, 3'b000, {32'h7000, 32'h0, 32'h0});
        @(negedge clock);
        drive_idle();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        sq_drained = 1'b1;
        #1;
        n_checks++;
        if (dispatch_hold !== 1'b0 || mispredict_count !== '0 || bp_recover_en !== 1'b0 || halted !== 1'b0)
            $display("FAIL reset_in_drain: hold=%b count=%0d bp=%b halted=%b want 0 0 0 0",
                     dispatch_hold, mispredict_count, bp_recover_en, halted);
        else n_pass++;
        exp_count = '0;
        run_mispredict("after_reset", 3'b110, 3'b010, {32'h0, 32'h0000_8888, 32'h0}, 1);
    endtask

    // Main sequence and final report
    initial begin
        reset      = 1'b1;
        sq_drained = 1'b1;
        drive_idle();
        test_reset();
        test_no_event();
        test_mispredict();
        test_sq_stall();
        test_random();
        test_halt();
        test_reset_in_drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
